my_sub_pipe: RTL and testbench

//   Two-stage pipelined subtractor: c = a - b with borrow, behind valid/ready handshakes.

---
 rtl/my_sub_pipe.sv | 142 ++++++++++++++
 tb/tb_my_sub_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/my_sub_pipe.sv
// my_sub_pipe: two-stage pipelined subtractor c = a - b with borrow.
// Optional underflow counter enabled by defining MY_SUB_UNDERFLOW_CNT_EN.
module my_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c
`ifdef MY_SUB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]      under_cnt
`endif
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  // stage 1 state: low-half difference plus raw high halves
  logic          s1_valid_q, s1_valid_d;
  logic [LO-1:0] s1_dlo_q, s1_dlo_d;
  logic          s1_blo_q, s1_blo_d;
  logic [HI-1:0] s1_ahi_q, s1_ahi_d;
  logic [HI-1:0] s1_bhi_q, s1_bhi_d;

  // stage 2 state: the full result
  logic          s2_valid_q, s2_valid_d;
  logic [WIDTH:0] c_q, c_d;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;

  logic [LO:0] lo_diff;
  logic [HI:0] hi_diff;

  // handshake: a stage moves when its successor can take the beat
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_xfer  = in_valid && s1_adv;
    out_xfer = s2_valid_q && out_ready;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign c         = c_q;

  // low half subtract feeding stage 1
  always_comb begin
    lo_diff    = {1'b0, a[LO-1:0]} - {1'b0, b[LO-1:0]};
    s1_valid_d = s1_valid_q;
    s1_dlo_d   = s1_dlo_q;
    s1_blo_d   = s1_blo_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_dlo_d = lo_diff[LO-1:0];
      s1_blo_d = lo_diff[LO];
      s1_ahi_d = a[WIDTH-1:LO];
      s1_bhi_d = b[WIDTH-1:LO];
    end
  end

  // high half subtract with the low-half borrow feeding stage 2
  always_comb begin
    hi_diff    = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q}
               - {{HI{1'b0}}, s1_blo_q};
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        c_d = {hi_diff[HI], hi_diff[HI-1:0], s1_dlo_q};
      end
    end
  end

  // stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= '0;
      s1_blo_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dlo_q   <= s1_dlo_d;
      s1_blo_q   <= s1_blo_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
    end
  end

  // stage 2 register; c stays put while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      c_q        <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
    end
  end

`ifdef MY_SUB_UNDERFLOW_CNT_EN
  logic [15:0] under_cnt_q, under_cnt_d;

  // count delivered results that borrowed out, saturating at all-ones
  always_comb begin
    under_cnt_d = under_cnt_q;
    if (out_xfer && c_q[WIDTH] && (under_cnt_q != 16'hFFFF)) begin
      under_cnt_d = under_cnt_q + 16'd1;
    end
  end

  // underflow counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      under_cnt_q <= '0;
    end else begin
      under_cnt_q <= under_cnt_d;
    end
  end

  assign under_cnt = under_cnt_q;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_my_sub_pipe.sv
// tb_my_sub_pipe: scoreboard bench for my_sub_pipe.
// Build with MY_SUB_UNDERFLOW_CNT_EN to also check under_cnt.
module tb_my_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   c;
`ifdef MY_SUB_UNDERFLOW_CNT_EN
  logic [15:0]  under_cnt;
`endif

  my_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c(c)
`ifdef MY_SUB_UNDERFLOW_CNT_EN
    ,
    .under_cnt(under_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_under = 0;
  logic [W:0] sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: the result is just the wide difference of the operands
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // one clock of stimulus; reports whether the beat was accepted
  task automatic cycle(input logic iv, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ordy,
                       output logic acc);
    @(negedge clk);
    in_valid  = iv;
    a         = x;
    b         = y;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (acc) sb.push_back(model(x, y));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    exp_under = 0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && sb.size() != 0; i++)
      cycle(1'b0, '0, '0, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", sb.size(), 0);
  endtask

  // monitor: every delivered result must be the oldest expected one
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {15'd0, c}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check("result", {15'd0, c}, {15'd0, e});
          if (e[W]) exp_under++;
        end
      end
    end
  end

  initial begin
    logic acc;
    int idx;
    int acc_cnt;
    int cyc;
    logic held;
    logic iv;
    logic [W-1:0] ra, rb;
    logic [W-1:0] sa[4];
    logic [W-1:0] sbv[4];

    // reset state and basic latency
    do_reset(2);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_in_ready", in_ready, 1);
    cycle(1'b1, 16'd1000, 16'd1, 1'b1, acc);
    check("basic_acc", acc, 1);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check("lat1_valid", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check("lat2_valid", out_valid, 1);
    check("lat2_c", c, 17'd999);
    drain();

    // underflow, wrap and borrow across halves
    cycle(1'b1, 16'h0000, 16'h0001, 1'b1, acc);
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, acc);
    cycle(1'b1, 16'h0100, 16'h0001, 1'b1, acc);
    cycle(1'b1, 16'h00FF, 16'hFF00, 1'b1, acc);
    drain();

    // stall: consumer holds off for 5 cycles
    for (int i = 0; i < 4; i++) begin
      sa[i]  = W'($urandom);
      sbv[i] = W'($urandom);
    end
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, sa[idx], sbv[idx], 1'b0, acc);
      if (acc) idx++;
    end
    check("stall_accepts", idx, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_c_first", {15'd0, c}, {15'd0, model(sa[0], sbv[0])});
    cyc = 0;
    while (idx < 4 && cyc < 50) begin
      cycle(1'b1, sa[idx], sbv[idx], 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("stall_all_accepted", idx, 4);
    drain();

    // mid-operation reset with both stages full
    cycle(1'b1, 16'h1234, 16'h0042, 1'b0, acc);
    cycle(1'b1, 16'h0001, 16'h0002, 1'b0, acc);
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, acc);
    check("pre_rst_full", in_ready, 0);
    do_reset(1);
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_c", c, 0);
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1, acc);
    check("no_stale", out_valid, 0);

`ifdef MY_SUB_UNDERFLOW_CNT_EN
    // underflow counting: three borrows and two non-borrows
    cycle(1'b1, 16'd5, 16'd9, 1'b1, acc);
    cycle(1'b1, 16'd9, 16'd5, 1'b1, acc);
    cycle(1'b1, 16'd0, 16'hFFFF, 1'b1, acc);
    cycle(1'b1, 16'd7, 16'd7, 1'b1, acc);
    cycle(1'b1, 16'h7FFF, 16'h8000, 1'b1, acc);
    drain();
    check("under_cnt3", under_cnt, 3);
`endif

    // random soak with random valid and ready
    acc_cnt = 0;
    cyc = 0;
    held = 1'b0;
    iv = 1'b0;
    ra = '0;
    rb = '0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      if (!held) begin
        iv = 1'($urandom_range(0, 1));
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 7) == 0) rb = ra;
      end
      cycle(iv, ra, rb, 1'($urandom_range(0, 1)), acc);
      held = iv && !acc;
      if (acc) acc_cnt++;
      cyc++;
    end
    check("soak_accepts", acc_cnt, 1000);
    drain();
`ifdef MY_SUB_UNDERFLOW_CNT_EN
    check("under_cnt_soak", under_cnt,
          (exp_under > 65535) ? 32'hFFFF : exp_under);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
